// File: rtl/sys_defs.sv
// Shared reservation-station definitions: entry index type, issue-arbiter FSM states
// and the default starvation threshold.
`ifndef RS_SZ
`define RS_SZ 5
`endif

package sys_defs;

    localparam int unsigned RS_SZ          = `RS_SZ;
    localparam int unsigned RS_IDX_W       = (RS_SZ > 1) ? $clog2(RS_SZ) : 1;
    localparam int unsigned RS_ARB_AGE_MAX = 7;

    typedef logic [RS_IDX_W-1:0] RS_IDX;

    typedef enum logic {
        RS_ARB_IDLE,
        RS_ARB_OFFER
    } RS_ARB_STATE;

endpackage

// File: rtl/rr_picker.sv
// Combinational circular priority picker: first set bit of req at or above start,
// wrapping modulo N.
module rr_picker #(
    parameter  int unsigned N  = 5,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        int unsigned j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned off = 0; off < N; off++) begin
            j = (32'(start) + off) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rs_issue_arbiter.sv
// Round-robin issue select for the reservation station with a registered, stall-stable grant.
// Optional starvation override by per-entry age counters when RS_ARB_AGE_EN is defined.
`ifndef RS_SZ
`define RS_SZ 5
`endif

module rs_issue_arbiter
    import sys_defs::*;
#(
    parameter  int unsigned N_ENTRIES = `RS_SZ,
    parameter  int unsigned AGE_MAX   = RS_ARB_AGE_MAX,
    localparam int unsigned IW        = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 interrupt,
    input  logic                 is_stall,
    input  logic [N_ENTRIES-1:0] req,
    output logic                 grant_en,
    output logic [IW-1:0]        grant_idx,
    output logic                 issue_fire,
    output logic                 starved
);

    RS_ARB_STATE          state_q;
    logic [IW-1:0]        grant_idx_q;
    logic [IW-1:0]        rr_ptr_q;
    logic                 starved_q;

    logic                 cur_req;
    logic                 fire;
    logic [N_ENTRIES-1:0] fire_mask;
    logic [N_ENTRIES-1:0] masked_req;
    logic [IW-1:0]        next_ptr;
    logic [IW-1:0]        rr_start;
    logic                 rr_found;
    logic [IW-1:0]        rr_idx;
    logic                 pick_found;
    logic [IW-1:0]        pick_idx;
    logic                 pick_starved;

    assign grant_en   = (state_q == RS_ARB_OFFER);
    assign grant_idx  = grant_idx_q;
    assign starved    = starved_q;
    assign cur_req    = req[grant_idx_q];
    assign fire       = grant_en & ~is_stall & cur_req & ~interrupt & ~reset;
    assign issue_fire = fire;

    // Clearing the fired entry keeps it from being re-picked before the RS issued bit lands.
    always_comb begin
        fire_mask = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            fire_mask[i] = fire && (grant_idx_q == IW'(i));
        end
    end

    assign masked_req = req & ~fire_mask;
    assign next_ptr   = (grant_idx_q == IW'(N_ENTRIES - 1)) ? '0 : grant_idx_q + IW'(1);
    assign rr_start   = fire ? next_ptr : rr_ptr_q;

    rr_picker #(.N(N_ENTRIES)) u_rr_pick (
        .req   (masked_req),
        .start (rr_start),
        .found (rr_found),
        .idx   (rr_idx)
    );

`ifdef RS_ARB_AGE_EN
    localparam int unsigned AW = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;

    logic [AW-1:0]        age_q [N_ENTRIES];
    logic [N_ENTRIES-1:0] aged;
    logic                 age_found;
    logic [IW-1:0]        age_idx;

    always_comb begin
        aged = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            aged[i] = masked_req[i] && (age_q[i] == AW'(AGE_MAX));
        end
    end

    rr_picker #(.N(N_ENTRIES)) u_age_pick (
        .req   (aged),
        .start ('0),
        .found (age_found),
        .idx   (age_idx)
    );

    // Ages count cycles spent requesting without firing, saturating at the threshold.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (reset || interrupt || !req[i] || fire_mask[i]) begin
                age_q[i] <= '0;
            end else if (age_q[i] != AW'(AGE_MAX)) begin
                age_q[i] <= age_q[i] + AW'(1);
            end
        end
    end

    assign pick_found   = rr_found | age_found;
    assign pick_idx     = age_found ? age_idx : rr_idx;
    assign pick_starved = age_found;
`else
    assign pick_found   = rr_found;
    assign pick_idx     = rr_idx;
    assign pick_starved = 1'b0;
`endif

    // Grant FSM: hold under stall, re-pick on fire or on removal of the offered entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RS_ARB_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            starved_q   <= 1'b0;
        end else if (interrupt) begin
            state_q     <= RS_ARB_IDLE;
            rr_ptr_q    <= '0;
            starved_q   <= 1'b0;
        end else begin
            case (state_q)
                RS_ARB_IDLE: begin
                    if (pick_found) begin
                        state_q     <= RS_ARB_OFFER;
                        grant_idx_q <= pick_idx;
                        starved_q   <= pick_starved;
                    end
                end
                RS_ARB_OFFER: begin
                    if (fire) begin
                        rr_ptr_q <= next_ptr;
                    end
                    if (fire || !cur_req) begin
                        if (pick_found) begin
                            grant_idx_q <= pick_idx;
                            starved_q   <= pick_starved;
                        end else begin
                            state_q     <= RS_ARB_IDLE;
                            starved_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= RS_ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Directed self-checking bench for rs_issue_arbiter (age scenario runs when RS_ARB_AGE_EN is defined).
`timescale 1ns/1ps

module tb_rs_issue_arbiter;

    localparam int unsigned N  = 5;
    localparam int unsigned IW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          interrupt;
    logic          is_stall;
    logic [N-1:0]  req;
    logic          grant_en;
    logic [IW-1:0] grant_idx;
    logic          issue_fire;
    logic          starved;

    int checks = 0;
    int errors = 0;

    rs_issue_arbiter #(.N_ENTRIES(N), .AGE_MAX(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .interrupt  (interrupt),
        .is_stall   (is_stall),
        .req        (req),
        .grant_en   (grant_en),
        .grant_idx  (grant_idx),
        .issue_fire (issue_fire),
        .starved    (starved)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        interrupt = 1'b0;
        is_stall  = 1'b0;
        req       = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        interrupt = 1'b0;
        is_stall  = 1'b0;
        req       = 5'b00000;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (grant_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_grant_en cycle %0d got %b exp 0", c, grant_en);
            end
            checks++;
            if (grant_idx !== 3'd0) begin
                errors++;
                $display("FAIL reset_grant_idx cycle %0d got %0d exp 0", c, grant_idx);
            end
            checks++;
            if (issue_fire !== 1'b0) begin
                errors++;
                $display("FAIL reset_issue_fire cycle %0d got %b exp 0", c, issue_fire);
            end
        end
    endtask

    task automatic test_rotation();
        logic [IW-1:0] exp_idx [6];
        exp_idx = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        do_reset();
        req = 5'b11111;
        tick();
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (issue_fire !== 1'b1) begin
                errors++;
                $display("FAIL rot_fire step %0d got %b exp 1", k, issue_fire);
            end
            checks++;
            if (grant_idx !== exp_idx[k]) begin
                errors++;
                $display("FAIL rot_idx step %0d got %0d exp %0d", k, grant_idx, exp_idx[k]);
            end
`ifndef RS_ARB_AGE_EN
            checks++;
            if (starved !== 1'b0) begin
                errors++;
                $display("FAIL rot_starved step %0d got %b exp 0", k, starved);
            end
`endif
            tick();
        end
        req = '0;
        tick();
        checks++;
        if (grant_en !== 1'b0) begin
            errors++;
            $display("FAIL rot_drain got %b exp 0", grant_en);
        end
    endtask

    // Stall hold, then a fire leaves rr_ptr at 4; the following offer is used for the interrupt case.
    task automatic test_stall_hold_and_interrupt();
        do_reset();
        req      = 5'b01000;
        is_stall = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (grant_en !== 1'b1 || grant_idx !== 3'd3) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got en=%b idx=%0d exp en=1 idx=3", c, grant_en, grant_idx);
            end
            checks++;
            if (issue_fire !== 1'b0) begin
                errors++;
                $display("FAIL stall_nofire cycle %0d got %b exp 0", c, issue_fire);
            end
            tick();
        end
        is_stall = 1'b0;
        #1;
        checks++;
        if (issue_fire !== 1'b1 || grant_idx !== 3'd3) begin
            errors++;
            $display("FAIL stall_release got fire=%b idx=%0d exp fire=1 idx=3", issue_fire, grant_idx);
        end
        tick();
        checks++;
        if (grant_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_single_fire got en=%b exp 0", grant_en);
        end
        req = 5'b10001;
        tick();
        checks++;
        if (grant_en !== 1'b1 || grant_idx !== 3'd4) begin
            errors++;
            $display("FAIL stall_rr_ptr got en=%b idx=%0d exp en=1 idx=4", grant_en, grant_idx);
        end
        interrupt = 1'b1;
        #1;
        checks++;
        if (issue_fire !== 1'b0) begin
            errors++;
            $display("FAIL intr_fire got %b exp 0", issue_fire);
        end
        tick();
        interrupt = 1'b0;
        checks++;
        if (grant_en !== 1'b0) begin
            errors++;
            $display("FAIL intr_grant_en got %b exp 0", grant_en);
        end
        tick();
        checks++;
        if (grant_en !== 1'b1 || grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL intr_rr_ptr got en=%b idx=%0d exp en=1 idx=0", grant_en, grant_idx);
        end
        req = '0;
        tick();
    endtask

    task automatic test_removal();
        do_reset();
        req      = 5'b00100;
        is_stall = 1'b1;
        tick();
        checks++;
        if (grant_en !== 1'b1 || grant_idx !== 3'd2) begin
            errors++;
            $display("FAIL rem_grant got en=%b idx=%0d exp en=1 idx=2", grant_en, grant_idx);
        end
        req = 5'b00001;
        #1;
        checks++;
        if (issue_fire !== 1'b0) begin
            errors++;
            $display("FAIL rem_nofire got %b exp 0", issue_fire);
        end
        tick();
        checks++;
        if (grant_en !== 1'b1 || grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL rem_repick got en=%b idx=%0d exp en=1 idx=0", grant_en, grant_idx);
        end
        is_stall = 1'b0;
        #1;
        checks++;
        if (issue_fire !== 1'b1) begin
            errors++;
            $display("FAIL rem_fire got %b exp 1", issue_fire);
        end
        tick();
        req = '0;
        checks++;
        if (grant_en !== 1'b0) begin
            errors++;
            $display("FAIL rem_idle got %b exp 0", grant_en);
        end
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        req      = 5'b00010;
        is_stall = 1'b1;
        tick();
        checks++;
        if (grant_en !== 1'b1 || grant_idx !== 3'd1) begin
            errors++;
            $display("FAIL rmo_grant got en=%b idx=%0d exp en=1 idx=1", grant_en, grant_idx);
        end
        reset    = 1'b1;
        is_stall = 1'b0;
        #1;
        checks++;
        if (issue_fire !== 1'b0) begin
            errors++;
            $display("FAIL rmo_nofire got %b exp 0", issue_fire);
        end
        tick();
        reset = 1'b0;
        checks++;
        if (grant_en !== 1'b0 || grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL rmo_drop got en=%b idx=%0d exp en=0 idx=0", grant_en, grant_idx);
        end
        req = '0;
    endtask

`ifdef RS_ARB_AGE_EN
    // Entry 4 loses three cycles while lower entries rotate through; the age path then beats rr.
    task automatic test_age();
        logic [N-1:0]  vec  [5];
        logic [IW-1:0] eidx [5];
        logic          estv [5];
        vec  = '{5'b10001, 5'b10011, 5'b10110, 5'b11100, 5'b11000};
        eidx = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3};
        estv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            req = vec[k];
            tick();
            checks++;
            if (grant_en !== 1'b1 || grant_idx !== eidx[k] || starved !== estv[k]) begin
                errors++;
                $display("FAIL age step %0d got en=%b idx=%0d starved=%b exp en=1 idx=%0d starved=%b",
                         k, grant_en, grant_idx, starved, eidx[k], estv[k]);
            end
        end
        req = '0;
        tick();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        interrupt = 1'b0;
        is_stall  = 1'b0;
        req       = '0;
        test_reset();
        test_rotation();
        test_stall_hold_and_interrupt();
        test_removal();
        test_reset_mid_offer();
`ifdef RS_ARB_AGE_EN
        test_age();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_issue_arbiter.md
# rs_issue_arbiter

Issue-select controller for the reservation station. Each cycle it takes the vector of RS entries that are eligible to issue and picks at most one. An entry is eligible when it is busy, not yet issued, and both operands are valid-or-ready. The pick is presented to the issue stage as a registered grant and held stable across issue-stage stalls. Selection is round-robin, so no RS slot (ALU, load, store, FP1, FP2) can monopolise the single issue port.

## Interface
- `N_ENTRIES`, default `` `RS_SZ `` (5): number of RS entries arbitrated.
- `AGE_MAX`, default 7: starvation threshold, used only when the age feature is compiled in.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `interrupt` in 1: synchronous squash; same-cycle priority over all other inputs.
- `is_stall` in 1: issue stage cannot accept this cycle.
- `req` in N_ENTRIES: bit i = entry i eligible (busy & !issued & operands ready).
- `grant_en` out 1: registered; a grant is being offered.
- `grant_idx` out $clog2(N_ENTRIES): registered index of the offered entry.
- `issue_fire` out 1: combinational, `grant_en & !is_stall & req[grant_idx]`; the RS marks the entry issued on this edge.
- `starved` out 1: registered; the current grant came from the age path (0 when the feature is off).

## Operation
- FSM with two states.
  - **IDLE**: `grant_en`=0.
  - **OFFER**: `grant_en`=1 and `grant_idx` valid.
- Pick function: first set bit of the masked request vector, scanning from `rr_ptr` upward and wrapping modulo N_ENTRIES.
  - `rr_ptr` is a $clog2(N_ENTRIES)-bit register.
  - The masked vector is `req` with the fired index cleared in the cycle of a fire. This prevents a double grant before the RS issued bit is visible.
- IDLE → OFFER when the masked `req` is nonzero. The pick result is registered into `grant_idx`.
- OFFER with `issue_fire`:
  - `rr_ptr` ← (`grant_idx`+1) mod N_ENTRIES; the wrap from N_ENTRIES-1 goes to 0.
  - The next pick is taken in the same cycle from the masked `req`.
  - If something is picked, the FSM stays in OFFER with the new index; otherwise it returns to IDLE.
- OFFER with `is_stall`=1 and `req[grant_idx]`=1: hold. `grant_idx`, `starved` and `rr_ptr` are unchanged.
- OFFER with `req[grant_idx]`=0 (the entry was removed): no fire. The FSM re-picks that cycle; `rr_ptr` is unchanged.
- `interrupt`=1:
  - Next state is IDLE and `rr_ptr` ← 0; ages are cleared.
  - `issue_fire` is forced to 0 in the same cycle.
- Throughput: one issue per cycle when `is_stall`=0 and requests are continuous.

## Timing
- Reset values: `grant_en`=0, `grant_idx`=0, `starved`=0, `rr_ptr`=0, all ages 0, FSM=IDLE. `issue_fire` is therefore 0.
- Latency: a request bit rising in cycle t gives `grant_en` at t+1 at the earliest, and `issue_fire` at t+1 if unstalled.
- `grant_idx` is stable for every cycle in which `grant_en`=1 and `is_stall`=1, provided `req[grant_idx]` stays high.
- Reset and `interrupt` are both sampled on the rising edge; reset wins over interrupt.
- Reset mid-OFFER drops the grant at the next edge with no fire.
- When `req`=0 in every cycle, the outputs never change.

## Configuration
- Macro: `RS_ARB_AGE_EN`.
- Defined:
  - Each entry has a $clog2(AGE_MAX+1)-bit age counter. It increments (saturating at AGE_MAX) each cycle that its `req` is 1 and it is not the fired index.
  - The counter clears when its entry fires or its `req` is 0.
  - If any age equals AGE_MAX, the lowest such index overrides the round-robin pick and `starved`=1 is registered with it. `rr_ptr` still advances past the fired index.
- Undefined:
  - Pure round-robin; no counters are instantiated.
  - `starved` is tied to 0.

## Structure
- Shared package (sys_defs):
  - `RS_IDX` typedef ($clog2(`` `RS_SZ ``) bits).
  - `RS_ARB_STATE` enum {RS_ARB_IDLE, RS_ARB_OFFER}.
  - Default `RS_ARB_AGE_MAX` constant.
- Sub-module `rr_picker`: purely combinational. Inputs are a request vector and a start pointer; outputs are `found` and `idx`. It is reused for the age path by giving it the start pointer 0.

## Test plan
- **Reset and idle**: reset=1 for 2 cycles, then `req`=5'b00000 for 5 cycles → `grant_en`=0, `grant_idx`=0 and `issue_fire`=0 throughout.
- **Round-robin rotation**: `req`=5'b11111 held, no stall → `issue_fire` every cycle with `grant_idx` sequence 0,1,2,3,4,0.
- **Stall hold**: `req`=5'b01000, `is_stall`=1 for 3 cycles, then 0 → `grant_idx`=3 is held for 3 cycles with `issue_fire`=0, then a single fire; afterwards `rr_ptr`=4.
- **Removal mid-offer**: grant on idx 2 under stall, then `req` → 5'b00001 → the next cycle gives `grant_idx`=0 with no fire on idx 2.
- **Interrupt**: while idx 4 is offered, pulse `interrupt` → `issue_fire`=0 that cycle; next cycle `grant_en`=0 and `rr_ptr`=0.
- **Age** (`RS_ARB_AGE_EN` defined, AGE_MAX=3): entry 4 held requesting while entries 0–3 re-request every cycle and `rr_ptr` is kept ahead of 4 → after 3 losing cycles, the grant goes to idx 4 with `starved`=1.
